// File: rtl/st_axi_ctrl.sv
`default_nettype none
// st_axi_ctrl: buffers EXU stores (st.b/st.h/st.w), formats byte lanes and strobes,
// and issues them in order as single-beat AXI writes over AW/W/B.
// Revision: 1.0
module st_axi_ctrl #(
  parameter int         DEPTH  = 2,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_misalign,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic [3:0]  awid,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        busy,
  output logic        err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [3:0]  strb_mem [DEPTH];
  logic [1:0]  size_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic [1:0]    state_q, state_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          misalign_q, misalign_d;
  logic          err_q, err_d;

  logic          accept;
  logic          misaligned;
  logic          push;
  logic          pop;
  logic          pending;
  logic [31:0]   fmt_data;
  logic [3:0]    fmt_strb;

  // Request decode and lane formatting; reserved size 11 counts as misaligned.
  always_comb begin
    accept     = st_valid & ~full_q;
    misaligned = 1'b0;
    fmt_data   = st_data;
    fmt_strb   = 4'b1111;
    case (st_size)
      2'b00: begin
        fmt_data = {4{st_data[7:0]}};
        fmt_strb = 4'b0001 << st_addr[1:0];
      end
      2'b01: begin
        misaligned = st_addr[0];
        fmt_data   = {2{st_data[15:0]}};
        fmt_strb   = 4'b0011 << st_addr[1:0];
      end
      2'b10: misaligned = |st_addr[1:0];
      default: misaligned = 1'b1;
    endcase
    push       = accept & ~misaligned;
    misalign_d = accept & misaligned;
  end

  always_comb begin
    pop      = (state_q == S_RESP) & bvalid;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    // Another entry remains behind the head being retired, or one arrives now.
    pending = (count_q > CW'(1)) | push;
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) || push) begin
          state_d   = S_REQ;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      S_REQ: begin
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bvalid) begin
          if (bresp != 2'b00) begin
            err_d = 1'b1;
          end
          if (pending) begin
            state_d   = S_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      state_q    <= S_IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      state_q    <= state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (resetn && push) begin
      addr_mem[wr_ptr_q] <= st_addr;
      data_mem[wr_ptr_q] <= fmt_data;
      strb_mem[wr_ptr_q] <= fmt_strb;
      size_mem[wr_ptr_q] <= st_size;
    end
  end

  assign st_ready    = ~full_q;
  assign st_misalign = misalign_q;
  assign awvalid     = awvalid_q;
  assign awaddr      = addr_mem[rd_ptr_q];
  assign awsize      = {1'b0, size_mem[rd_ptr_q]};
  assign awid        = AXI_ID;
  assign wvalid      = wvalid_q;
  assign wdata       = data_mem[rd_ptr_q];
  assign wstrb       = strb_mem[rd_ptr_q];
  assign wlast       = wvalid_q;
  assign bready      = (state_q == S_RESP);
  assign busy        = (count_q != '0) | (state_q != S_IDLE);
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_st_axi_ctrl.sv
`default_nettype none
// tb_st_axi_ctrl: directed and random stores against a transaction-level queue model.
// Revision: 1.0
module tb_st_axi_ctrl;

  localparam int         DEPTH = 2;
  localparam logic [3:0] ID    = 4'hA;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_size = '0;
  logic        st_misalign;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [3:0]  awid;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [1:0]  bresp = '0;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  st_axi_ctrl #(.DEPTH(DEPTH), .AXI_ID(ID)) dut (
    .clk(clk), .resetn(resetn),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_size(st_size), .st_misalign(st_misalign),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .busy(busy), .err(err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  size;
  } exp_t;

  exp_t q[$];
  bit   aw_seen, w_seen, err_m, last_acc;
  int   total = 0;
  int   bad = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'b11) || ((a % (32'd1 << s)) != 32'd0);
  endfunction

  function automatic exp_t fmt(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    exp_t e;
    e.addr = a;
    e.size = {1'b0, s};
    case (s)
      2'b00: begin
        e.data = 32'(d[7:0]) * 32'h01010101;
        e.strb = 4'(1 << (a % 4));
      end
      2'b01: begin
        e.data = 32'(d[15:0]) * 32'h00010001;
        e.strb = 4'(3 << (a % 4));
      end
      default: begin
        e.data = d;
        e.strb = 4'hF;
      end
    endcase
    return e;
  endfunction

  // Every entry in the model queue is a write the controller still owes the bus.
  task automatic check_state(input bit mis);
    chk1("st_misalign", st_misalign, mis);
    chk1("st_ready", st_ready, q.size() < DEPTH);
    chk1("busy", busy, q.size() != 0);
    chk1("awvalid", awvalid, (q.size() != 0) && !aw_seen);
    chk1("wvalid", wvalid, (q.size() != 0) && !w_seen);
    chk1("bready", bready, (q.size() != 0) && aw_seen && w_seen);
    chk1("err", err, err_m);
    chk32("awid", 32'(awid), 32'(ID));
    if (wvalid) chk1("wlast", wlast, 1'b1);
  endtask

  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input bit awr, input bit wr, input bit bv,
                      input logic [1:0] br);
    bit mis;
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    awready  = awr;
    wready   = wr;
    bresp    = br;
    bvalid   = bv && (q.size() != 0) && aw_seen && w_seen;
    #1;
    last_acc = v && st_ready;
    mis      = last_acc && is_mis(a, s);
    if (q.size() != 0) begin
      if (awvalid && awready) begin
        chk32("awaddr", awaddr, q[0].addr);
        chk32("awsize", 32'(awsize), 32'(q[0].size));
        aw_seen = 1'b1;
      end
      if (wvalid && wready) begin
        chk32("wdata", wdata, q[0].data);
        chk32("wstrb", 32'(wstrb), 32'(q[0].strb));
        w_seen = 1'b1;
      end
      if (bvalid && bready) begin
        if (br != 2'b00) err_m = 1'b1;
        q.delete(0);
        aw_seen = 1'b0;
        w_seen  = 1'b0;
      end
    end
    if (last_acc && !mis) q.push_back(fmt(a, d, s));
    @(posedge clk);
    @(negedge clk);
    check_state(mis);
  endtask

  task automatic do_reset(input int n);
    resetn   = 1'b0;
    st_valid = 1'b0;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    q.delete();
    aw_seen = 1'b0;
    w_seen  = 1'b0;
    err_m   = 1'b0;
    check_state(1'b0);
    resetn = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      step(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00);
    end
    chk1("drain_busy", busy, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    do_reset(2);

    // st.b lane replication and strobe
    step(1'b1, 32'h1c000101, 32'h1234565a, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00);
    chk32("tp_b_wdata", wdata, 32'h5a5a5a5a);
    chk32("tp_b_wstrb", 32'(wstrb), 32'h2);
    chk32("tp_b_awsize", 32'(awsize), 32'h0);
    step(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00);
    step(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00);

    // st.h upper half, then st.w
    step(1'b1, 32'h1c000102, 32'h0000beef, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00);
    chk32("tp_h_wdata", wdata, 32'hbeefbeef);
    chk32("tp_h_wstrb", 32'(wstrb), 32'hC);
    chk32("tp_h_awsize", 32'(awsize), 32'h1);
    drain();
    step(1'b1, 32'h1c000104, 32'hcafef00d, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00);
    chk32("tp_w_wstrb", 32'(wstrb), 32'hF);
    drain();

    // misaligned requests are consumed and dropped
    step(1'b1, 32'h1c000101, 32'h11111111, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00);
    chk1("mis_h_pulse", st_misalign, 1'b1);
    step(1'b1, 32'h1c000106, 32'h22222222, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00);
    chk1("mis_w_pulse", st_misalign, 1'b1);
    step(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00);

    // back-pressure on AW fills the buffer and stalls the third store
    step(1'b1, 32'h1c000200, 32'h000000a1, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b1, 32'h1c000204, 32'h000000a2, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00);
    chk1("stall_ready", st_ready, 1'b0);
    step(1'b1, 32'h1c000208, 32'h000000a3, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00);
    chk1("third_stalled", last_acc, 1'b0);
    last_acc = 1'b0;
    for (int i = 0; i < 20 && !last_acc; i++) begin
      step(1'b1, 32'h1c000208, 32'h000000a3, 2'b10, 1'b1, 1'b1, 1'b1, 2'b00);
    end
    chk1("third_accepted", last_acc, 1'b1);
    drain();

    // W three cycles after AW, then the reverse
    step(1'b1, 32'h1c000300, 32'h0badf00d, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00);
    step(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
    step(1'b1, 32'h1c000304, 32'h00c0ffee, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00);
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    step(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);

    // sticky bus error
    step(1'b1, 32'h1c000400, 32'h01234567, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00);
    step(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00);
    step(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10);
    chk1("err_set", err, 1'b1);
    step(1'b1, 32'h1c000404, 32'h89abcdef, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00);
    drain();
    chk1("err_sticky", err, 1'b1);

    // reset while a write is in REQ
    step(1'b1, 32'h1c000500, 32'h55aa55aa, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00);
    do_reset(1);
    chk1("rst_awvalid", awvalid, 1'b0);
    chk1("rst_err", err, 1'b0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)),
           32'h20000000 | ($urandom & 32'h00000FFF),
           $urandom,
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/st_axi_ctrl.md
Name: st_axi_ctrl

Overview:
- Store controller between the core's EXU store path (st.b / st.h / st.w) and the AXI write channels of the memory bus.
- Accepts store requests, buffers them in a small FIFO and formats byte lanes and strobes.
- Sequences one AXI single-beat write at a time through the AW, W and B channels.
- Reports misaligned stores, bus errors and a busy flag so the core can drain stores before fences or halts.

Parameters:
- DEPTH, 2, number of store-buffer entries (power of two, at least 2).
- AXI_ID, 4'd0, constant value driven on awid.

Ports:
- clk  in  1  core clock.
- resetn  in  1  reset. One clock domain; reset is synchronous and active-low.
- st_valid  in  1  store request valid.
- st_ready  out  1  controller can accept a request this cycle.
- st_addr  in  32  byte address.
- st_data  in  32  store data, right-justified.
- st_size  in  2  00 byte, 01 halfword, 10 word; 11 is reserved and treated as misaligned.
- st_misalign  out  1  one-cycle pulse: the last request was rejected.
- awvalid  out  1  AW valid.
- awready  in  1  AW ready.
- awaddr  out  32  write address.
- awsize  out  3  {1'b0, size}.
- awid  out  4  AXI_ID.
- wvalid  out  1  W valid.
- wready  in  1  W ready.
- wdata  out  32  lane-formatted data.
- wstrb  out  4  byte strobes.
- wlast  out  1  always 1 while wvalid is high.
- bvalid  in  1  B valid.
- bready  out  1  B ready.
- bresp  in  2  B response.
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- err  out  1  sticky bus error.

Behaviour:
- Reset (resetn low at a clk edge):
  - FIFO pointers and count go to 0; FSM goes to IDLE.
  - awvalid, wvalid, bready, st_misalign, err and busy are all 0.
  - st_ready is 1 from the first cycle after reset.
  - Reset mid-transaction drops awvalid and wvalid in the next cycle and loses buffered stores. This is accepted because the slave shares resetn.
- Accept:
  - A request is accepted when st_valid and st_ready are both high.
  - st_ready is the inverse of the registered full flag. A pop in the same cycle does not free the slot for that cycle.
- Misalignment check:
  - Misaligned cases: halfword with addr[0] set; word with addr[1:0] non-zero; any request with size 11.
  - A misaligned request is consumed (handshake completes) but not enqueued.
  - st_misalign pulses high for the following cycle.
- Lane formatting, done at enqueue:
  - Byte: wdata = {4{d[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - Halfword: wdata = {2{d[15:0]}}, wstrb = 4'b0011 << addr[1:0].
  - Word: wdata = d, wstrb = 4'b1111.
  - awaddr is the unmodified st_addr.
- FSM:
  - IDLE: if the FIFO is non-empty, go to REQ and assert awvalid and wvalid together in the next cycle.
  - REQ:
    - awvalid drops after its handshake; wvalid drops after its handshake. The two are tracked independently, so any ordering is legal, including both in one cycle.
    - awaddr, wdata and wstrb are held stable from the head entry while their valid is high.
    - When both handshakes have completed, go to RESP.
  - RESP:
    - bready is held at 1.
    - On bvalid: pop the head entry; if bresp is non-zero, set err (cleared only by reset).
    - Then return to IDLE, or go straight back to REQ if another entry is pending.
- Latency:
  - Request accepted at cycle N into an empty, idle controller: awvalid/wvalid high at N+1.
  - B handshake at cycle M with a pending entry: next awvalid/wvalid high at M+1.
- Simultaneous events:
  - Enqueue and pop in the same cycle: count unchanged, pointers both advance.
  - Pointers wrap modulo DEPTH.
- busy is combinational from the FIFO count and FSM state.

Test Plan:
- st.b, addr 0x1c000101, data 0x1234565a, awready=wready=1, bvalid one cycle later -> wdata 0x5a5a5a5a, wstrb 4'b0010, awsize 3'b000, awvalid at N+1, busy returns to 0 after B.
- st.h, addr 0x1c000102, data 0x0000beef -> wdata 0xbeefbeef, wstrb 4'b1100, awsize 3'b001; st.w at 0x1c000104 -> wstrb 4'b1111.
- st.h at 0x1c000101, then st.w at 0x1c000106 -> two st_misalign pulses, no awvalid, FIFO stays empty.
- Hold awready=0 and issue three stores back-to-back -> st_ready goes low after two accepts; third request is stalled. Release awready -> writes issue in order.
- wready asserted 3 cycles after awready, then the reverse order -> exactly one AW and one W handshake each, no state advance until both complete.
- bresp=2'b10 on the first write -> err=1 and stays 1 through further OKAY writes. Pulse resetn low during REQ -> all outputs 0 next cycle, FIFO empty.
